// File: rtl/chol_pkg.sv
// chol_pkg: shared definitions for the 2x2 Cholesky datapath blocks.
//   - Q16.16 word geometry and saturation limits
//   - packed-field offsets of the 96-bit L / A buses
//   - FSM state encoding for chol_llt_2
//   - saturation helpers used by the multiplier and the A22 adder
package chol_pkg;

  localparam int FRAC_BITS = 16;
  localparam int WORD      = 32;

  localparam logic [WORD-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [WORD-1:0] Q_MIN = 32'h8000_0000;

  // Field offsets within the packed 96-bit buses (L11/A11, L21/A21, L22/A22)
  localparam int F11_LSB = 0;
  localparam int F21_LSB = 32;
  localparam int F22_LSB = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_SUM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Q32.32 product -> Q16.16. Taking bits [47:16] drops fraction bits,
  // which for two's complement is truncation toward -inf. The result is
  // representable only when bits [63:47] are a pure sign extension.
  function automatic logic [WORD-1:0] sat_prod(input logic [63:0] p);
    logic [WORD-1:0] res;
    if ((&p[63:47]) || !(|p[63:47])) res = p[47:16];
    else if (p[63])                  res = Q_MIN;
    else                             res = Q_MAX;
    return res;
  endfunction

  // 33-bit signed add of two Q16.16 words, clamped back to 32 bits.
  function automatic logic [WORD-1:0] sat_add(input logic [WORD-1:0] a,
                                              input logic [WORD-1:0] b);
    logic [WORD:0]   s;
    logic [WORD-1:0] res;
    s = {a[WORD-1], a} + {b[WORD-1], b};
    if (s[WORD] == s[WORD-1]) res = s[WORD-1:0];
    else if (s[WORD])         res = Q_MIN;
    else                      res = Q_MAX;
    return res;
  endfunction

endpackage

// File: rtl/chol_fx_mult.sv
// chol_fx_mult: pipelined signed 32x32 multiplier producing saturated Q16.16.
//   clk, rst_n  : clock, async active-low reset (clears all pipeline state)
//   i_valid     : operand pair present this cycle
//   i_tag       : 2-bit index carried alongside the operands
//   i_a, i_b    : Q16.16 signed operands
//   o_valid     : result present
//   o_tag       : index of the result
//   o_res       : saturated Q16.16 product
// Operands are registered on the issue edge, then the product passes
// through MULT_LAT register stages; o_* reflects the last stage.
module chol_fx_mult
  import chol_pkg::*;
#(
  parameter int MULT_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [1:0]      i_tag,
  input  logic [WORD-1:0] i_a,
  input  logic [WORD-1:0] i_b,
  output logic            o_valid,
  output logic [1:0]      o_tag,
  output logic [WORD-1:0] o_res
);

  logic signed [WORD-1:0] r_a;
  logic signed [WORD-1:0] r_b;
  logic                   r_v;
  logic [1:0]             r_t;
  logic signed [63:0]     r_p  [MULT_LAT];
  logic                   r_pv [MULT_LAT];
  logic [1:0]             r_pt [MULT_LAT];
  logic signed [63:0]     w_prod;

  assign w_prod = 64'(r_a) * 64'(r_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_v <= 1'b0;
      r_t <= '0;
      for (int i = 0; i < MULT_LAT; i++) begin
        r_p[i]  <= '0;
        r_pv[i] <= 1'b0;
        r_pt[i] <= '0;
      end
    end else begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_v     <= i_valid;
      r_t     <= i_tag;
      r_p[0]  <= w_prod;
      r_pv[0] <= r_v;
      r_pt[0] <= r_t;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_p[i]  <= r_p[i-1];
        r_pv[i] <= r_pv[i-1];
        r_pt[i] <= r_pt[i-1];
      end
    end
  end

  assign o_valid = r_pv[MULT_LAT-1];
  assign o_tag   = r_pt[MULT_LAT-1];
  assign o_res   = sat_prod(r_p[MULT_LAT-1]);

endmodule

// File: rtl/chol_llt_2.sv
// chol_llt_2: rebuilds A = L*L^T for a 2x2 lower Cholesky factor (Q16.16).
//   clk, rst_n  : clock, async active-low reset
//   i_l         : packed L {L22, L21, L11}
//   i_l_valid   : L offered this cycle
//   o_l_ready   : L accepted (S_IDLE only, and never during/at reset)
//   o_a         : packed A {A22, A21, A11}
//   o_a_valid   : A held valid until consumed
//   i_a_ready   : downstream consumes A
//   o_state     : current FSM state (debug)
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high; the producer holds data stable while
// valid is high and ready is low.
// Four products share one multiplier: L11*L11, L21*L11, L21*L21,
// L22*L22, tagged 0..3. Products are collected by tag whenever they
// emerge (even while still issuing, for short pipelines).
module chol_llt_2
  import chol_pkg::*;
#(
  parameter int MULT_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [95:0]   i_l,
  input  logic          i_l_valid,
  output logic          o_l_ready,
  output logic [95:0]   o_a,
  output logic          o_a_valid,
  input  logic          i_a_ready,
  output state_t        o_state
);

  state_t          r_state;
  state_t          w_next;
  logic            r_live;     // low until the first edge after reset release
  logic [WORD-1:0] r_l11;
  logic [WORD-1:0] r_l21;
  logic [WORD-1:0] r_l22;
  logic [1:0]      r_idx;
  logic [WORD-1:0] r_prod [4];
  logic [95:0]     r_a;
  logic            r_a_valid;

  logic            w_l_ready;
  logic            w_iss_valid;
  logic [WORD-1:0] w_iss_a;
  logic [WORD-1:0] w_iss_b;
  logic            w_m_valid;
  logic [1:0]      w_m_tag;
  logic [WORD-1:0] w_m_res;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_l_valid && r_live)            w_next = S_ISSUE;
      S_ISSUE: if (r_idx == 2'd3)                  w_next = S_DRAIN;
      S_DRAIN: if (w_m_valid && w_m_tag == 2'd3)   w_next = S_SUM;
      S_SUM:                                       w_next = S_DONE;
      S_DONE:  if (i_a_ready)                      w_next = S_IDLE;
      default:                                     w_next = S_IDLE;
    endcase
  end

  // Output logic: ready and operand selection for the shared multiplier
  always_comb begin
    w_l_ready   = 1'b0;
    w_iss_valid = 1'b0;
    w_iss_a     = '0;
    w_iss_b     = '0;
    case (r_state)
      S_IDLE:  w_l_ready = r_live;
      S_ISSUE: begin
        w_iss_valid = 1'b1;
        case (r_idx)
          2'd0:    begin w_iss_a = r_l11; w_iss_b = r_l11; end
          2'd1:    begin w_iss_a = r_l21; w_iss_b = r_l11; end
          2'd2:    begin w_iss_a = r_l21; w_iss_b = r_l21; end
          default: begin w_iss_a = r_l22; w_iss_b = r_l22; end
        endcase
      end
      default: ;
    endcase
  end

  chol_fx_mult #(.MULT_LAT(MULT_LAT)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_iss_valid),
    .i_tag   (r_idx),
    .i_a     (w_iss_a),
    .i_b     (w_iss_b),
    .o_valid (w_m_valid),
    .o_tag   (w_m_tag),
    .o_res   (w_m_res)
  );

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_l11     <= '0;
      r_l21     <= '0;
      r_l22     <= '0;
      r_idx     <= '0;
      for (int i = 0; i < 4; i++) r_prod[i] <= '0;
      r_a       <= '0;
      r_a_valid <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (r_state == S_IDLE && i_l_valid && r_live) begin
        r_l11 <= i_l[F11_LSB +: WORD];
        r_l21 <= i_l[F21_LSB +: WORD];
        r_l22 <= i_l[F22_LSB +: WORD];
        r_idx <= '0;
      end
      if (r_state == S_ISSUE) r_idx <= r_idx + 2'd1;
      if (w_m_valid) r_prod[w_m_tag] <= w_m_res;
      if (r_state == S_SUM) begin
        r_a[F11_LSB +: WORD] <= r_prod[0];
        r_a[F21_LSB +: WORD] <= r_prod[1];
        r_a[F22_LSB +: WORD] <= sat_add(r_prod[2], r_prod[3]);
        r_a_valid            <= 1'b1;
      end
      if (r_state == S_DONE && i_a_ready) r_a_valid <= 1'b0;
    end
  end

  assign o_l_ready = w_l_ready;
  assign o_a       = r_a;
  assign o_a_valid = r_a_valid;
  assign o_state   = r_state;

endmodule

// File: doc/chol_llt_2.md
# chol_llt_2

Reconstructs a 2×2 symmetric matrix A = L·Lᵀ from its packed lower Cholesky factor L. All values are signed Q16.16. One shared pipelined multiplier is time-multiplexed over four products, behind a valid/ready handshake on both sides. The block is the inverse stage of the 2×2 Cholesky factor path: it feeds factor outputs back for residual checks and covariance re-assembly in the sigma-point datapath.

## Interface
- MULT_LAT, 4: pipeline depth of the shared multiplier in cycles; legal range 1–8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- L  in  96  packed factor: [31:0]=L11, [63:32]=L21, [95:64]=L22 (Q16.16, signed).
- L_valid  in  1  L is valid this cycle.
- L_ready  out  1  block accepts L; high only in S_IDLE.
- A  out  96  packed result: [31:0]=A11, [63:32]=A21, [95:64]=A22 (Q16.16, signed).
- A_valid  out  1  A is valid; held until it is consumed.
- A_ready  in  1  downstream consumes A when it is high together with A_valid.

## Operation
- Results:
  - A11 = L11².
  - A21 = L21·L11.
  - A22 = L21² + L22².
- Each product is a 64-bit signed Q32.32 value. The result is bits [47:16], truncated toward −∞.
- Product saturation: if bits [63:47] are not all equal, the result saturates to 0x7FFF_FFFF when the sign is positive and to 0x8000_0000 when negative.
- A22: the two saturated 32-bit terms are added in 33 bits, then saturated to 32 bits with the same rule.
- States:
  - S_IDLE: L_ready=1. On L_valid, capture L into internal registers and go to S_ISSUE.
  - S_ISSUE: 4 cycles. Issue the operand pairs in order (L11,L11), (L21,L11), (L21,L21), (L22,L22), one per cycle, each tagged with a 2-bit index.
  - S_DRAIN: collect products by tag as the multiplier's valid bit emerges. When tag 3 returns, go to S_SUM.
  - S_SUM: 1 cycle. Form A22, register A, set A_valid, go to S_DONE.
  - S_DONE: hold A and A_valid stable. On A_ready, clear A_valid and return to S_IDLE.
- Input L is not required to stay stable after acceptance.
- L_valid outside S_IDLE is ignored; L_ready is low there.
- Handshake in S_DONE: when A_valid & A_ready occur in the same cycle as L_valid, the new L is not accepted that cycle. It is accepted on the next cycle at the earliest (one bubble).
- Reset values: A=0, A_valid=0, L_ready=0 while rst_n is low, then 1 (S_IDLE) from the first edge after release. Internal operand registers, multiplier pipeline and valid bits are all 0.
- Reset mid-operation: all in-flight products are discarded, with no stale A_valid after release.

## Timing
- Accept edge = edge N, where L_valid & L_ready are both high.
- Issue edges: N+1 … N+4.
- Product k is available at edge N+1+k+MULT_LAT.
- A_valid rises at edge N+MULT_LAT+6. Default latency is 10 cycles.
- Throughput with A_ready tied high: one matrix per MULT_LAT+8 cycles.
- The multiplier is fully pipelined. Its clock enable is tied high, and products are qualified by a valid/tag shift register.

## Structure
- chol_pkg holds:
  - FRAC_BITS=16, WORD=32.
  - Q16.16 saturation limits.
  - Packed-field offsets (shared with the forward Cholesky blocks).
  - State encoding for S_IDLE … S_DONE.
- Sub-module chol_fx_mult: signed 32×32 multiplier, MULT_LAT stages, with valid and 2-bit tag pipelined alongside. Outputs the saturated Q16.16 result. The top level adds no separate sat logic for products.

## Test plan
- Basic: L11=0x0002_0000 (2.0), L21=0x0001_0000 (1.0), L22=0x0003_0000 (3.0) -> A11=0x0004_0000, A21=0x0002_0000, A22=0x000A_0000. A_valid rises exactly 10 cycles after acceptance.
- Negative: L11=2.0, L21=0xFFFE_8000 (−1.5), L22=0x0001_0000 -> A21=0xFFFD_0000 (−3.0), A22=0x0003_4000 (3.25).
- Saturation:
  - L11=0x0100_0000 (256.0) -> A11=0x7FFF_FFFF.
  - L21=L22=0x0096_0000 (150.0) -> A22=0x7FFF_FFFF (45000 overflows).
- Backpressure: hold A_ready low for 12 cycles after A_valid -> A and A_valid stay stable, L_ready=0, a pulsed L_valid is ignored. Then raise A_ready alongside L_valid -> the new L is accepted the following cycle.
- Reset mid-operation: drop rst_n 2 cycles after the accept edge -> all outputs are 0 asynchronously, no A_valid within 20 cycles after release, and the next transaction is correct.
- Back-to-back: 8 random transactions with A_ready=1 -> results match a reference model bit-exactly, at one matrix per 12 cycles.
